onehot_req_issuer: RTL and testbench



---
 rtl/onehot_req_issuer.sv | 152 +++++++++++++++
 tb/tb_onehot_req_issuer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_req_issuer.sv
// Sticky request capture plus round-robin issuer presenting one strictly one-hot grant at a time.
// Build option: define REQ_EDGE_EN for rising-edge capture with lost-request (ovf) detection.
module onehot_req_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rdy,
    output logic [7:0] oh,
    output logic       vld,
    output logic [7:0] pend,
    output logic [3:0] pend_cnt,
    output logic       ovf
);

    // Handshake: a grant transfers on a cycle where vld and rdy are both high; once raised,
    // vld and oh hold steady until that transfer, and vld drops for at least one cycle after it.

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] oh_q, oh_d;
    logic       vld_q, vld_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gidx_q, gidx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;

    logic [7:0] set_mask;
    logic [7:0] clear_mask;
    logic       accept;
    logic       sel_found;
    logic [2:0] sel_idx;
    logic [2:0] cand;

    assign accept     = vld_q & rdy;
    assign clear_mask = accept ? oh_q : 8'h00;

`ifdef REQ_EDGE_EN
    logic [7:0] req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 8'h00;
        end else begin
            req_q <= req;
        end
    end

    assign set_mask = req & ~req_q;
    // A new request landing on a still-pending, not-being-served bit is lost.
    assign ovf_d    = ovf_q | (|(set_mask & pend_q & ~clear_mask));
`else
    assign set_mask = req;
    assign ovf_d    = 1'b0;
`endif

    // Set wins over clear on the same bit.
    assign pend_d = (pend_q & ~clear_mask) | set_mask;

    always_comb begin
        cnt_d = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt_d = cnt_d + {3'b000, pend_d[k]};
        end
    end

    // First pending bit at or above ptr, wrapping 7 -> 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + i[2:0];
            if (!sel_found && pend_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // State register (also holds all registered outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 8'h00;
            oh_q    <= 8'h00;
            vld_q   <= 1'b0;
            ptr_q   <= 3'd0;
            gidx_q  <= 3'd0;
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            oh_q    <= oh_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel_found) state_d = S_GRANT;
            S_GRANT: if (rdy)       state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        oh_d   = oh_q;
        vld_d  = vld_q;
        ptr_d  = ptr_q;
        gidx_d = gidx_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    oh_d   = 8'b0000_0001 << sel_idx;
                    vld_d  = 1'b1;
                    gidx_d = sel_idx;
                end
            end
            S_GRANT: begin
                if (rdy) begin
                    oh_d  = 8'h00;
                    vld_d = 1'b0;
                    ptr_d = gidx_q + 3'd1;
                end
            end
            default: begin
                oh_d  = 8'h00;
                vld_d = 1'b0;
            end
        endcase
    end

    assign oh       = oh_q;
    assign vld      = vld_q;
    assign pend     = pend_q;
    assign pend_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_onehot_req_issuer.sv
// Self-checking bench for onehot_req_issuer: directed scenarios plus randomized traffic vs. a reference model.
module tb_onehot_req_issuer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rdy;
  logic [7:0] oh;
  logic       vld;
  logic [7:0] pend;
  logic [3:0] pend_cnt;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;

  onehot_req_issuer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rdy      (rdy),
    .oh       (oh),
    .vld      (vld),
    .pend     (pend),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pending set as a bit vector, current grant as an index (-1 = nothing offered).
  logic [7:0] m_pend;
  int         m_g;
  int         m_ptr;
  logic       m_ovf;
  logic [7:0] m_req_prev;

  logic [7:0] exp_q[$];

  task automatic model_reset();
    m_pend     = 8'h00;
    m_g        = -1;
    m_ptr      = 0;
    m_ovf      = 1'b0;
    m_req_prev = 8'h00;
  endtask

  task automatic model_step();
    logic [7:0] setm;
    bit         acc;
    int         new_g;
    int         new_ptr;
`ifdef REQ_EDGE_EN
    setm = req & ~m_req_prev;
`else
    setm = req;
`endif
    acc     = (m_g >= 0) && rdy;
    new_g   = m_g;
    new_ptr = m_ptr;
`ifdef REQ_EDGE_EN
    for (int k = 0; k < 8; k++)
      if (setm[k] && m_pend[k] && !(acc && m_g == k)) m_ovf = 1'b1;
`endif
    if (m_g < 0) begin
      for (int i = 0; i < 8; i++) begin
        int j;
        j = (m_ptr + i) % 8;
        if (new_g < 0 && m_pend[j]) new_g = j;
      end
    end else if (acc) begin
      new_ptr = (m_g + 1) % 8;
      new_g   = -1;
    end
    for (int k = 0; k < 8; k++) begin
      if (acc && m_g == k) m_pend[k] = 1'b0;
      if (setm[k]) m_pend[k] = 1'b1;
    end
    m_req_prev = req;
    m_g        = new_g;
    m_ptr      = new_ptr;
  endtask

  function automatic logic [21:0] exp_vec();
    logic [7:0] e_oh;
    int         c;
    e_oh = 8'h00;
    if (m_g >= 0) e_oh[m_g] = 1'b1;
    c = 0;
    for (int k = 0; k < 8; k++) c += int'(m_pend[k]);
    return {e_oh, (m_g >= 0), m_pend, 4'(c), m_ovf};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {oh, vld, pend, pend_cnt, ovf};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    req   = 8'h00;
    rdy   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    n_checks++;
    if (obs_vec() !== 22'h0) begin
      n_errors++;
      $display("FAIL reset_values: got %h expected %h", obs_vec(), 22'h0);
    end
    repeat (3) cycle();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    reset_dut();
    req = 8'h04; rdy = 1'b1;
    cycle();
    req = 8'h00;
    n_checks++;
    if (pend !== 8'h04 || vld !== 1'b0) begin
      n_errors++;
      $display("FAIL single_capture: pend=%h vld=%b expected pend=04 vld=0", pend, vld);
    end
    cycle();
    n_checks++;
    if (oh !== 8'h04 || vld !== 1'b1) begin
      n_errors++;
      $display("FAIL single_grant: oh=%h vld=%b expected oh=04 vld=1", oh, vld);
    end
    cycle();
    n_checks++;
    if (vld !== 1'b0 || oh !== 8'h00 || pend !== 8'h00 || pend_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL single_accept: vld=%b oh=%h pend=%h cnt=%0d expected all zero", vld, oh, pend, pend_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    reset_dut();
    req = 8'h81; rdy = 1'b1;
    cycle();
    req = 8'h00;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (vld) got.push_back(oh);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL wrap_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (got.size() != 2 || got[0] !== 8'h01 || got[1] !== 8'h80) begin
      n_errors++;
      $display("FAIL wrap_order: got %0d grants first=%h expected 01 then 80", got.size(),
               (got.size() > 0) ? got[0] : 8'h00);
    end
    // Pointer wrapped to 0: with 0x03 pending bit 0 must win.
    req = 8'h03;
    cycle();
    req = 8'h00;
    cycle();
    n_checks++;
    if (oh !== 8'h01 || vld !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_ptr: oh=%h vld=%b expected oh=01 vld=1", oh, vld);
    end
    repeat (4) cycle();
  endtask

  task automatic test_backpressure();
    reset_dut();
    req = 8'h10; rdy = 1'b0;
    cycle();
    req = 8'h00;
    cycle();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req = 8'h20;
      cycle();
      req = 8'h00;
      n_checks++;
      if (oh !== 8'h10 || vld !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_hold%0d: oh=%h vld=%b expected oh=10 vld=1", c, oh, vld);
      end
    end
    n_checks++;
    if (pend !== 8'h30 || pend_cnt !== 4'd2) begin
      n_errors++;
      $display("FAIL bp_pend: pend=%h cnt=%0d expected 30 / 2", pend, pend_cnt);
    end
    rdy = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (oh !== 8'h20 || vld !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_next: oh=%h vld=%b expected oh=20 vld=1", oh, vld);
    end
    cycle();
  endtask

  task automatic test_all_pending();
    int cnt_seen[$];
    reset_dut();
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h01 << k);
    req = 8'hFF; rdy = 1'b1;
    cycle();
    req = 8'h00;
    n_checks++;
    if (pend_cnt !== 4'd8) begin
      n_errors++;
      $display("FAIL all_cnt8: cnt=%0d expected 8", pend_cnt);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      cycle();
      if (vld) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (oh !== e) begin
          n_errors++;
          $display("FAIL all_order: oh=%h expected %h", oh, e);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL all_timeout: %0d grants missing expected 0", exp_q.size());
    end
    cycle();
    n_checks++;
    if (pend !== 8'h00 || pend_cnt !== 4'd0 || vld !== 1'b0) begin
      n_errors++;
      $display("FAIL all_drain: pend=%h cnt=%0d vld=%b expected 00/0/0", pend, pend_cnt, vld);
    end
  endtask

`ifdef REQ_EDGE_EN
  task automatic test_ovf();
    reset_dut();
    rdy = 1'b0;
    req = 8'h08; cycle();
    req = 8'h00; cycle();
    req = 8'h08; cycle();
    req = 8'h00;
    n_checks++;
    if (ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_set: ovf=%b expected 1", ovf);
    end
    rdy = 1'b1; cycle();
    rdy = 1'b0; cycle();
    n_checks++;
    if (ovf !== 1'b1 || vld !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_sticky: ovf=%b vld=%b expected 1/0", ovf, vld);
    end
  endtask
`else
  task automatic test_level();
    int grants;
    reset_dut();
    grants = 0;
    req = 8'h08; rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (vld) begin
        grants++;
        n_checks++;
        if (oh !== 8'h08 || ovf !== 1'b0) begin
          n_errors++;
          $display("FAIL level_grant: oh=%h ovf=%b expected 08/0", oh, ovf);
        end
      end
    end
    req = 8'h00;
    n_checks++;
    if (grants != 6) begin
      n_errors++;
      $display("FAIL level_count: grants=%0d expected 6", grants);
    end
    repeat (3) cycle();
  endtask
`endif

  task automatic test_reset_mid_grant();
    int waited;
    reset_dut();
    req = 8'h06; rdy = 1'b0;
    cycle();
    req = 8'h00;
    waited = 0;
    while (!(vld === 1'b1) && waited < 10) begin
      cycle();
      waited++;
    end
    n_checks++;
    if (oh !== 8'h02 || vld !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_setup: oh=%h vld=%b expected 02/1", oh, vld);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 22'h0) begin
      n_errors++;
      $display("FAIL mid_reset: got %h expected %h", obs_vec(), 22'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL mid_after: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rdy = 1'($urandom_range(0, 1));
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random_c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    req = 8'h00;
    rdy = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    rdy   = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_all_pending();
`ifdef REQ_EDGE_EN
    test_ovf();
`else
    test_level();
`endif
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
